// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver peripheral: register map, bit layout, FSM encoding.
package uart_pkg;

  localparam logic [31:0] RXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;

  localparam int ST_VALID   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_RXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO is taken only alongside a pop.
// Pointers carry one extra wrap bit so count = wr - rd covers 0..DEPTH.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: synchronizer, bit FSM, receive FIFO, RXDATA/STATUS/CTRL registers.
// Bytes land in the FIFO at the stop-bit sample edge; ReadData is zero unless a decoded read is active.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0030,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        UART_RX,
  output logic        irq
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic            rx_s1, rx_s2, rx_prev;
  logic            rx_en, irq_en;
  logic            overrun, frame_err;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            stop_smp;

  logic            sel_rx, sel_st, sel_ct;
  logic            pop, pop_eff, push;
  logic            fifo_full, fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [7:0]      fifo_head;
  logic            status_wr;
  logic            overrun_set, ferr_set;
  logic [31:0]     status_word, ctrl_word;
  logic            unused_wdata;

  assign sel_rx = (Addr == BASE_ADDR + RXDATA_OFS);
  assign sel_st = (Addr == BASE_ADDR + STATUS_OFS);
  assign sel_ct = (Addr == BASE_ADDR + CTRL_OFS);
  assign unused_wdata = ^WriteData[31:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    stop_smp = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s2) begin
          state_d = RX_START;
          bit_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
          cnt_d   = '0;
          state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_s2, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d    = '0;
          stop_smp = 1'b1;
          state_d  = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Disabling the receiver abandons any frame in flight.
    if (!rx_en) begin
      state_d  = RX_IDLE;
      cnt_d    = '0;
      stop_smp = 1'b0;
    end
  end

  assign pop         = MemRd & sel_rx;
  assign pop_eff     = pop & ~fifo_empty;
  assign push        = stop_smp & rx_s2;
  assign overrun_set = push & fifo_full & ~pop_eff;
  assign ferr_set    = stop_smp & ~rx_s2;
  assign status_wr   = MemWr & sel_st;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(shreg_q),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  // Flag set takes priority over a coincident write-one-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_en     <= 1'b0;
      irq_en    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (MemWr && sel_ct) begin
        rx_en  <= WriteData[CTRL_RXEN];
        irq_en <= WriteData[CTRL_IRQEN];
      end
      overrun   <= overrun_set | (overrun & ~(status_wr & WriteData[ST_OVERRUN]));
      frame_err <= ferr_set | (frame_err & ~(status_wr & WriteData[ST_FERR]));
    end
  end

  always_comb begin
    status_word                      = '0;
    status_word[ST_VALID]            = ~fifo_empty;
    status_word[ST_FULL]             = fifo_full;
    status_word[ST_OVERRUN]          = overrun;
    status_word[ST_FERR]             = frame_err;
    status_word[ST_CNT_LSB +: CNTW]  = fifo_count;
    ctrl_word                        = '0;
    ctrl_word[CTRL_RXEN]             = rx_en;
    ctrl_word[CTRL_IRQEN]            = irq_en;
  end

  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (sel_rx && !fifo_empty) ReadData = {24'b0, fifo_head};
      else if (sel_st)           ReadData = status_word;
      else if (sel_ct)           ReadData = ctrl_word;
    end
  end

  assign irq = irq_en & (~fifo_empty | overrun | frame_err);

endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Memory-mapped UART receiver peripheral that acts as a responder on the processor's single-cycle data bus (MemRd/MemWr/Addr/WriteData/ReadData) and as the receiving end of the serial 8N1 link. It deserializes bytes from `UART_RX` into a small FIFO and exposes data, status and control registers. It raises an interrupt request towards the processor's interrupt logic. It sits next to the data memory, and its ReadData is OR-combined with the other bus responders.

## Interface
- `BASE_ADDR`, 32'h4000_0030: word address of RXDATA; STATUS = BASE+4, CTRL = BASE+8.
- `CLKS_PER_BIT`, 868: clk cycles per serial bit; must be ≥ 4 and even.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of two, ≥ 2.
- `clk` in 1: single clock for the entire block.
- `reset` in 1: asynchronous, active-high.
- `MemRd` in 1: bus read strobe.
- `MemWr` in 1: bus write strobe.
- `Addr` in 32: byte address; only exact matches on the three register addresses decode.
- `WriteData` in 32: write data.
- `ReadData` out 32: read data.
- `UART_RX` in 1: serial input; idles high.
- `irq` out 1: level interrupt request.

## Operation
- `UART_RX` is passed through a 2-flop synchronizer. Both flops reset to 1.
- RX FSM states and transitions:
  - IDLE: a synchronized falling edge while rx_en = 1 moves to START and clears the bit counter.
  - START: waits CLKS_PER_BIT/2 cycles, then samples. If the sample is low, go to DATA. If it is high, it was a glitch: return to IDLE with no flag.
  - DATA: samples every CLKS_PER_BIT cycles, 8 bits, LSB first. After bit 7, go to STOP.
  - STOP: samples after CLKS_PER_BIT cycles. If the sample is high, push the byte; if the FIFO is full, set overrun and drop the byte. If the sample is low, set frame_err and discard the byte. Return to IDLE in either case.
- The FIFO uses read/write pointers of log2(FIFO_DEPTH)+1 bits. count = wr − rd, modulo wrap.
- Registers:
  - RXDATA (read-only): returns {24'b0, head byte}, or 0 when the FIFO is empty. A read with the FIFO non-empty pops one entry at the clock edge.
  - STATUS: bit0 valid (count ≠ 0), bit1 full, bit2 overrun, bit3 frame_err, bits[8+log2(DEPTH):8] count; all other bits 0. Writing 1 to bit2 or bit3 clears that flag; other write bits are ignored.
  - CTRL (R/W): bit0 rx_en, bit1 irq_en. Other bits read 0.
- `ReadData` is 0 unless MemRd = 1 and Addr decodes to a register. This requirement lets the output be OR-combined with other responders.
- Writes to RXDATA or to undecoded addresses have no effect.
- `irq` = irq_en & (valid | overrun | frame_err).
- Clearing rx_en aborts any frame in progress: the FSM returns to IDLE on the next edge. FIFO contents and flags are kept.

## Timing
- Reset values: `ReadData` = 0, `irq` = 0, CTRL = 0, FIFO empty, overrun = 0, frame_err = 0, FSM = IDLE.
- `ReadData` is combinational from Addr/MemRd in the same cycle. Pop, CTRL writes and W1C clears take effect at that cycle's rising edge.
- A byte becomes visible (valid = 1) on the edge after the stop-bit sample. This is 2 + 9.5·CLKS_PER_BIT (±1) cycles after the falling edge of `UART_RX`.
- A new start bit is accepted from the cycle after the stop sample, so back-to-back frames are received without loss.
- Push and pop in the same cycle:
  - FIFO full: the push is accepted, no overrun is set, and count is unchanged.
  - FIFO empty: the pop is ignored and the push is accepted.
- An overrun or frame_err event coinciding with a W1C of the same bit: the flag stays set (set wins).
- `reset` asserted mid-frame or mid-access immediately restores all reset values.

## Structure
- Shared package `uart_pkg` holds:
  - register offsets (RXDATA_OFS = 0, STATUS_OFS = 4, CTRL_OFS = 8);
  - STATUS/CTRL bit positions;
  - FSM state encoding (IDLE, START, DATA, STOP).
- Sub-module `uart_rx_fifo` is a parameterized synchronous FIFO with push/pop/full/empty/count and a combinational head output. The top module holds the synchronizer, FSM, baud counter, register decode and flags.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and default BASE/FIFO_DEPTH.
- Basic receive: write CTRL = 3, send 0xA5 → about 156 cycles later STATUS reads 0x101 and irq = 1. A read of RXDATA returns 0xA5; on the next cycle STATUS reads 0x000 and irq = 0.
- Overrun: send 0x01–0x05 back-to-back without reading → STATUS = 0x407. Four reads return 01, 02, 03, 04, then 0. Writing STATUS = 0x4 clears bit2.
- Framing error: send 0x3C with the stop bit driven low → STATUS = 0x008, FIFO stays empty, irq = 1. Writing 0x8 clears the flag and irq.
- Glitch: drive `UART_RX` low for 4 cycles only → no push, no flags, FSM back in IDLE.
- Simultaneous push/pop: with the FIFO full (0x11–0x14), pop RXDATA in the cycle of the stop sample of 0x55 → read returns 0x11, count stays 4, overrun = 0, last entry = 0x55.
- Abort and reset: clear CTRL mid-frame → no byte is received. Assert reset mid-frame with 2 bytes queued → STATUS = 0, CTRL = 0, irq = 0.
